// File: rtl/dds_ctrl.sv
// DDS control front-end: turns button pulses into a saturating frequency word,
// a waveform select and an automatic triangular frequency sweep.
module dds_ctrl #(
    parameter int FREQ_W    = 12,
    parameter int FREQ_MIN  = 1,
    parameter int FREQ_MAX  = 4095,
    parameter int FREQ_INIT = 1,
    parameter int STEP      = 16,
    parameter int SWEEP_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_wave,
    input  logic              btn_sweep,
    output logic [FREQ_W-1:0] freq_ctl,
    output logic [1:0]        wave_sel,
    output logic              sweep_active,
    output logic              freq_upd
);
    localparam int CNT_W = (SWEEP_DIV > 2) ? $clog2(SWEEP_DIV) : 1;

    localparam logic [FREQ_W:0]   L_MAX_X  = (FREQ_W+1)'(FREQ_MAX);
    localparam logic [FREQ_W:0]   L_MIN_X  = (FREQ_W+1)'(FREQ_MIN);
    localparam logic [FREQ_W:0]   L_STEP_X = (FREQ_W+1)'(STEP);
    localparam logic [FREQ_W-1:0] L_MAX    = FREQ_W'(FREQ_MAX);
    localparam logic [FREQ_W-1:0] L_MIN    = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0] L_INIT   = FREQ_W'(FREQ_INIT);
    localparam logic [FREQ_W-1:0] L_STEP   = FREQ_W'(STEP);
    localparam logic [CNT_W-1:0]  L_LAST   = CNT_W'(SWEEP_DIV - 1);

    typedef enum logic [1:0] {S_MANUAL, S_UP, S_DN} state_t;

    state_t            r_state;
    logic [FREQ_W-1:0] r_freq;
    logic [1:0]        r_wave;
    logic              r_active;
    logic              r_upd;
    logic [CNT_W-1:0]  r_cnt;

    logic [FREQ_W:0]   w_sum;
    logic [FREQ_W-1:0] w_up;
    logic [FREQ_W-1:0] w_dn;

    // Saturating step results; compares in FREQ_W+1 bits so nothing wraps.
    assign w_sum = {1'b0, r_freq} + L_STEP_X;
    assign w_up  = (w_sum >= L_MAX_X) ? L_MAX : w_sum[FREQ_W-1:0];
    assign w_dn  = ({1'b0, r_freq} <= (L_MIN_X + L_STEP_X)) ? L_MIN : (r_freq - L_STEP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_MANUAL;
            r_freq   <= L_INIT;
            r_wave   <= 2'd0;
            r_active <= 1'b0;
            r_upd    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_upd <= 1'b0;
            if (btn_wave)
                r_wave <= r_wave + 2'd1;

            case (r_state)
                S_MANUAL: begin
                    // Mode change takes priority over any step press.
                    if (btn_sweep) begin
                        r_state  <= S_UP;
                        r_active <= 1'b1;
                        r_cnt    <= '0;
                    end else if (btn_up && !btn_down) begin
                        r_freq <= w_up;
                        r_upd  <= (w_up != r_freq);
                    end else if (btn_down && !btn_up) begin
                        r_freq <= w_dn;
                        r_upd  <= (w_dn != r_freq);
                    end
                end
                S_UP, S_DN: begin
                    if (btn_sweep) begin
                        r_state  <= S_MANUAL;
                        r_active <= 1'b0;
                        r_cnt    <= '0;
                    end else if (r_cnt == L_LAST) begin
                        r_cnt <= '0;
                        if (r_state == S_UP) begin
                            r_freq <= w_up;
                            r_upd  <= (w_up != r_freq);
                            if (w_up == L_MAX)
                                r_state <= S_DN;
                        end else begin
                            r_freq <= w_dn;
                            r_upd  <= (w_dn != r_freq);
                            if (w_dn == L_MIN)
                                r_state <= S_UP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state  <= S_MANUAL;
                    r_active <= 1'b0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    assign freq_ctl     = r_freq;
    assign wave_sel     = r_wave;
    assign sweep_active = r_active;
    assign freq_upd     = r_upd;
endmodule

// File: tb/tb_dds_ctrl.sv
// Bench for dds_ctrl: directed test-plan steps plus random button traffic,
// all checked against a behavioural model of the control rules.
module tb_dds_ctrl;
    localparam int FREQ_W    = 12;
    localparam int FREQ_MIN  = 1;
    localparam int FREQ_MAX  = 64;
    localparam int FREQ_INIT = 1;
    localparam int STEP      = 16;
    localparam int SWEEP_DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              btn_up = 1'b0, btn_down = 1'b0, btn_wave = 1'b0, btn_sweep = 1'b0;
    logic [FREQ_W-1:0] freq_ctl;
    logic [1:0]        wave_sel;
    logic              sweep_active;
    logic              freq_upd;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model
    int m_freq, m_wave, m_ticks;
    bit m_sweep, m_rising, m_upd;

    dds_ctrl #(
        .FREQ_W(FREQ_W), .FREQ_MIN(FREQ_MIN), .FREQ_MAX(FREQ_MAX),
        .FREQ_INIT(FREQ_INIT), .STEP(STEP), .SWEEP_DIV(SWEEP_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_wave(btn_wave), .btn_sweep(btn_sweep),
        .freq_ctl(freq_ctl), .wave_sel(wave_sel),
        .sweep_active(sweep_active), .freq_upd(freq_upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int f_up(input int f);
        return (f + STEP >= FREQ_MAX) ? FREQ_MAX : f + STEP;
    endfunction

    function automatic int f_dn(input int f);
        return (f - STEP <= FREQ_MIN) ? FREQ_MIN : f - STEP;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".freq"},   32'(freq_ctl),     32'(m_freq));
        chk({tag, ".wave"},   32'(wave_sel),     32'(m_wave));
        chk({tag, ".active"}, 32'(sweep_active), 32'(m_sweep));
        chk({tag, ".upd"},    32'(freq_upd),     32'(m_upd));
    endtask

    task automatic model_reset();
        m_freq = FREQ_INIT; m_wave = 0; m_ticks = 0;
        m_sweep = 0; m_rising = 1; m_upd = 0;
    endtask

    // One clock with the given pulses; called #1 after a rising edge.
    task automatic cycle(input bit u, input bit d, input bit w, input bit s, input string tag);
        int nf;
        btn_up = u; btn_down = d; btn_wave = w; btn_sweep = s;
        @(posedge clk);
        nf = m_freq;
        if (w) m_wave = (m_wave + 1) % 4;
        if (!m_sweep) begin
            if (s) begin
                m_sweep = 1; m_rising = 1; m_ticks = 0;
            end else if (u && !d) nf = f_up(m_freq);
            else if (d && !u) nf = f_dn(m_freq);
        end else if (s) begin
            m_sweep = 0; m_ticks = 0;
        end else begin
            m_ticks++;
            if (m_ticks == SWEEP_DIV) begin
                m_ticks = 0;
                if (m_rising) begin
                    nf = f_up(m_freq);
                    if (nf == FREQ_MAX) m_rising = 0;
                end else begin
                    nf = f_dn(m_freq);
                    if (nf == FREQ_MIN) m_rising = 1;
                end
            end
        end
        m_upd  = (nf != m_freq);
        m_freq = nf;
        #1;
        btn_up = 0; btn_down = 0; btn_wave = 0; btn_sweep = 0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1;
        check_all(tag);
    endtask

    initial begin
        int r;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("reset");
        chk("reset.freq_const", 32'(freq_ctl), 32'd1);

        // Manual stepping up to and past the upper bound
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, "up");
        chk("up.sat_freq", 32'(freq_ctl), 32'd64);
        chk("up.sat_noupd", 32'(freq_upd), 32'd0);

        // Down to and past the lower bound
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, "down");
        chk("down.sat_freq", 32'(freq_ctl), 32'd1);

        // Simultaneous up/down at 33
        cycle(1, 0, 0, 0, "to17");
        cycle(1, 0, 0, 0, "to33");
        cycle(1, 1, 0, 0, "updown");
        chk("updown.freq33", 32'(freq_ctl), 32'd33);

        // Waveform cycling leaves the frequency alone
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, "wave");
        chk("wave.sel1", 32'(wave_sel), 32'd1);

        // Full triangular sweep from 1
        do_reset("reset2");
        cycle(0, 0, 0, 1, "sweep_on");
        for (int i = 0; i < 9 * SWEEP_DIV; i++) cycle(0, 0, 0, 0, "sweep");
        chk("sweep.end17", 32'(freq_ctl), 32'd17);

        // Exit on the tick cycle at 33
        do_reset("reset3");
        cycle(0, 0, 0, 1, "sweep_on2");
        for (int i = 0; i < 2 * SWEEP_DIV; i++) cycle(0, 0, 0, 0, "sweep2");
        for (int i = 0; i < SWEEP_DIV - 1; i++) cycle(0, 0, 0, 0, "sweep2_hold");
        cycle(0, 0, 0, 1, "exit_tick");
        chk("exit.freq33", 32'(freq_ctl), 32'd33);
        chk("exit.inactive", 32'(sweep_active), 32'd0);
        cycle(1, 0, 0, 0, "exit_up");
        chk("exit.up49", 32'(freq_ctl), 32'd49);

        // Mid-sweep reset, then re-entry timing
        cycle(0, 0, 1, 1, "sweep_on3");
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, "sweep3");
        do_reset("reset_mid");
        chk("reset_mid.wave", 32'(wave_sel), 32'd0);
        cycle(0, 0, 0, 1, "reenter");
        for (int i = 0; i < SWEEP_DIV - 1; i++) cycle(0, 0, 0, 0, "reenter_wait");
        chk("reenter.hold1", 32'(freq_ctl), 32'd1);
        cycle(0, 0, 0, 0, "reenter_step");
        chk("reenter.step17", 32'(freq_ctl), 32'd17);
        chk("reenter.upd", 32'(freq_upd), 32'd1);

        // Random button traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) do_reset("rnd_reset");
            else cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
                       $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 4, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
